// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
// Optional build macro used by the loader: LOADER_TIMEOUT_EN.
package loader_pkg;

    // Frame-parser states.
    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        ACK,
        HALTED_ERR
    } loader_state_t;

    // Ack bytes returned to the host: 'K' for a good load, 'E' for any error.
    localparam logic [7:0] ACK_OK  = 8'h4B;
    localparam logic [7:0] ACK_ERR = 8'h45;

    // Default frame start marker.
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Byte address of instruction-memory word 0 as seen by the core.
    localparam logic [31:0] IMEM_BASE = 32'h8000_0000;

    // Core-visible byte address of a given instruction-memory word index.
    function automatic logic [31:0] imem_byte_addr(input logic [15:0] word_index);
        return IMEM_BASE + {14'd0, word_index, 2'b00};
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Little-endian byte-to-word packer for the boot loader.
// Collects four payload bytes into one 32-bit word and emits a registered
// one-cycle write strobe with the completed word on the cycle after lane 3.
module loader_word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_last,
    output logic        word_we,
    output logic [31:0] word_data
);

    logic [1:0]  lane_q;
    logic [23:0] asm_q;
    logic        we_q;
    logic [31:0] data_q;

    // The byte now being accepted completes a word.
    assign word_last = byte_valid && (lane_q == 2'd3);

    assign word_we   = we_q;
    assign word_data = data_q;

    // Lane counter, assembly register and write strobe.
    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values; blocking here would make the order of
    // statements change the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= 2'd0;
            asm_q  <= 24'd0;
            we_q   <= 1'b0;
            data_q <= 32'd0;
        end else begin
            we_q <= 1'b0;
            if (clear) begin
                lane_q <= 2'd0;
                asm_q  <= 24'd0;
            end else if (byte_valid) begin
                if (lane_q == 2'd3) begin
                    // Upper byte joins the three held lanes; the copy into
                    // data_q frees the assembly register for the next word.
                    data_q <= {byte_data, asm_q};
                    we_q   <= 1'b1;
                    lane_q <= 2'd0;
                end else begin
                    case (lane_q)
                        2'd0:    asm_q[7:0]   <= byte_data;
                        2'd1:    asm_q[15:8]  <= byte_data;
                        default: asm_q[23:16] <= byte_data;
                    endcase
                    lane_q <= lane_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// UART boot loader: parses SYNC, LEN(16b LE, words), payload, CSUM frames
// from the receive byte stream, writes the payload into instruction memory,
// holds the core while loading and answers with a single ack byte.
// Optional build macro: LOADER_TIMEOUT_EN adds an inter-byte timeout that
// aborts a stalled frame with an error ack.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              load_done
);

    // Capacity in words, one bit wider than LEN so DEPTH itself is representable.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    loader_state_t     state_q, state_d;

    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [16:0]       word_cnt_q;
    logic [7:0]        csum_q;
    logic [7:0]        tx_data_q;
    logic              core_hold_q;
    logic              load_done_q;
    logic [ADDR_W-1:0] waddr_q;

    // Control decoded by the next-state logic.
    logic              start;
    logic              ack_load;
    logic [7:0]        ack_code;
    logic              hold_release;
    logic              timeout;

    logic [15:0]       len_full;
    logic              data_byte;
    logic              word_last;
    logic              last_word;

    assign len_full  = {rx_data, len_lo_q};
    assign data_byte = rx_valid && (state_q == DATA);
    assign last_word = (word_cnt_q + 17'd1) == {1'b0, len_q};

    loader_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start),
        .byte_valid (data_byte),
        .byte_data  (rx_data),
        .word_last  (word_last),
        .word_we    (imem_we),
        .word_data  (imem_wdata)
    );

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] idle_cnt_q;
    logic        frame_active;

    assign frame_active = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                          (state_q == DATA)   || (state_q == CSUM);

    // Inter-byte idle counter; restarts on every byte and outside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= 32'd0;
        end else if (!frame_active || rx_valid) begin
            idle_cnt_q <= 32'd0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
        end
    end

    assign timeout = frame_active && !rx_valid &&
                     (idle_cnt_q >= 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout            = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        start        = 1'b0;
        ack_load     = 1'b0;
        ack_code     = ACK_ERR;
        hold_release = 1'b0;

        unique case (state_q)
            IDLE, HALTED_ERR: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = LEN_LO;
                    start   = 1'b1;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    if ({1'b0, len_full} > DEPTH) begin
                        state_d  = ACK;
                        ack_load = 1'b1;
                        ack_code = ACK_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_last && last_word) begin
                    state_d = CSUM;
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    state_d  = ACK;
                    ack_load = 1'b1;
                    ack_code = (rx_data == csum_q) ? ACK_OK : ACK_ERR;
                end
            end
            ACK: begin
                // Received bytes are dropped until the ack is taken.
                if (tx_ready) begin
                    if (tx_data_q == ACK_OK) begin
                        state_d      = IDLE;
                        hold_release = 1'b1;
                    end else begin
                        state_d = HALTED_ERR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeout) begin
            state_d  = ACK;
            ack_load = 1'b1;
            ack_code = ACK_ERR;
        end
    end

    // Frame datapath: length, word index, checksum, ack byte and core hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_q    <= 8'd0;
            len_q       <= 16'd0;
            word_cnt_q  <= 17'd0;
            csum_q      <= 8'd0;
            tx_data_q   <= 8'd0;
            core_hold_q <= 1'b0;
            load_done_q <= 1'b0;
            waddr_q     <= '0;
        end else begin
            load_done_q <= hold_release;

            if (start) begin
                word_cnt_q  <= 17'd0;
                csum_q      <= 8'd0;
                core_hold_q <= 1'b1;
            end

            if (rx_valid && (state_q == LEN_LO)) begin
                len_lo_q <= rx_data;
            end

            if (rx_valid && (state_q == LEN_HI)) begin
                len_q <= len_full;
            end

            if (data_byte) begin
                csum_q <= csum_q + rx_data;
            end

            // Address is captured alongside the packer's data copy so both
            // appear together with the write strobe one cycle later.
            if (word_last) begin
                waddr_q    <= word_cnt_q[ADDR_W-1:0];
                word_cnt_q <= word_cnt_q + 17'd1;
            end

            if (ack_load) begin
                tx_data_q <= ack_code;
            end

            if (hold_release) begin
                core_hold_q <= 1'b0;
            end
        end
    end

    assign tx_valid   = (state_q == ACK);
    assign tx_data    = tx_data_q;
    assign imem_waddr = waddr_q;
    assign core_hold  = core_hold_q;
    assign load_done  = load_done_q;

endmodule
